// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding, slice width and index sizing.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int ALU_SLICE_W = 32;

  function automatic int idx_width(input int words);
    return (words <= 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/cla_adder.sv
// W-bit carry-look-ahead adder: 4-bit look-ahead groups with a rippled group carry.
module cla_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int NG = W / 4;

  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W-1:0] c;
  logic [NG:0]  gc;

  assign p     = a ^ b;
  assign g     = a & b;
  assign gc[0] = cin;

  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      localparam int B = gi * 4;
      logic grp_g;
      logic grp_p;

      assign c[B]   = gc[gi];
      assign c[B+1] = g[B] | (p[B] & gc[gi]);
      assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[gi]);
      assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & gc[gi]);

      assign grp_g = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                   | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign grp_p = p[B+3] & p[B+2] & p[B+1] & p[B];

      assign gc[gi+1] = grp_g | (grp_p & gc[gi]);
    end
  endgenerate

  assign sum  = p ^ c;
  assign cout = gc[NG];

endmodule

// File: rtl/cla_mp_seq.sv
// Multi-precision add/subtract sequencer: streams WORDS slices through one shared
// cla_adder, LSB slice first, with the inter-slice carry held in a register.
module cla_mp_seq
  import alu_pkg::*;
#(
  parameter int W     = ALU_SLICE_W,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic               op_sub,
  input  logic [W*WORDS-1:0] a,
  input  logic [W*WORDS-1:0] b,
  output logic [W*WORDS-1:0] result,
  output logic               carry_out,
  output logic               overflow,
  output logic               done_valid,
  input  logic               done_ready
);

  localparam int              IW       = idx_width(WORDS);
  localparam logic [IW-1:0]   LAST_IDX = IW'(WORDS - 1);

  state_e                     state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic                       carry_q, carry_d;
  logic                       op_sub_q, op_sub_d;
  logic [WORDS-1:0][W-1:0]    a_q, a_d;
  logic [WORDS-1:0][W-1:0]    b_q, b_d;
  logic [WORDS-1:0][W-1:0]    result_q, result_d;
  logic                       carry_out_q, carry_out_d;
  logic                       overflow_q, overflow_d;
  logic                       done_valid_q, done_valid_d;

  logic [W-1:0]               a_slice;
  logic [W-1:0]               b_eff;
  logic [W-1:0]               sum;
  logic                       cout;

  // Subtraction is A + ~B + 1: the +1 enters as the initial carry loaded on accept.
  assign a_slice = a_q[idx_q];
  assign b_eff   = b_q[idx_q] ^ {W{op_sub_q}};

  cla_adder #(.W(W)) u_cla_adder (a_slice, b_eff, carry_q, sum, cout);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    carry_d      = carry_q;
    op_sub_d     = op_sub_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    carry_out_d  = carry_out_q;
    overflow_d   = overflow_q;
    done_valid_d = done_valid_q;

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d      = a;
          b_d      = b;
          op_sub_d = op_sub;
          idx_d    = '0;
          carry_d  = op_sub;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d[idx_q] = sum;
        carry_d         = cout;
        idx_d           = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          carry_out_d  = cout;
          overflow_d   = (a_slice[W-1] == b_eff[W-1]) && (sum[W-1] != a_slice[W-1]);
          done_valid_d = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (done_ready) begin
          done_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        done_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      op_sub_q     <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      carry_out_q  <= 1'b0;
      overflow_q   <= 1'b0;
      done_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      carry_q      <= carry_d;
      op_sub_q     <= op_sub_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      carry_out_q  <= carry_out_d;
      overflow_q   <= overflow_d;
      done_valid_q <= done_valid_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign result      = result_q;
  assign carry_out   = carry_out_q;
  assign overflow    = overflow_q;
  assign done_valid  = done_valid_q;

endmodule
